mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and load/store unit.
// Optional fetch starvation guard enabled by macro ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [XLEN-1:0]   ls_addr,
    input  logic [XLEN-1:0]   ls_wdata,
    input  logic [7:0]        ls_wmask,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [XLEN-1:0]   ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;
    // 1 = LSU owns the bus, 0 = fetch
    logic   owner_q, owner_d;
    // fetch word select within the 64-bit beat
    logic   off_q, off_d;
    logic   sel_ls;
    logic   cur_ls;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    // LSU wins unless fetch has waited through LIMIT LSU grants
    always_comb begin
        sel_ls = ls_req && !(if_req && (cnt_q == LIMIT));
    end

    // Count LSU grants taken while fetch waits; any fetch grant clears
    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt) begin
            cnt_d = '0;
        end else if (ls_gnt && if_req && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Starvation counter register
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // The limit only matters when the guard is built in
    logic [31:0] unused_limit;
    assign unused_limit = 32'(STARVE_LIMIT);

    // Strict LSU priority
    always_comb begin
        sel_ls = ls_req;
    end
`endif

    // Next state, owner selection and bus steering
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        off_d     = off_q;
        cur_ls    = owner_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;

        unique case (state_q)
            IDLE: begin
                cur_ls = sel_ls;
                if (if_req || ls_req) begin
                    mem_req = 1'b1;
                    owner_d = sel_ls;
                    state_d = mem_gnt ? WAIT : HOLD;
                end
            end
            HOLD: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if_rvalid = !owner_q;
                    ls_rvalid = owner_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mem_req) begin
            if (cur_ls) begin
                mem_we    = ls_we;
                mem_addr  = ls_addr;
                mem_wdata = ls_wdata;
                mem_wmask = ls_we ? ls_wmask : 8'h00;
                ls_gnt    = mem_gnt;
            end else begin
                mem_addr  = if_addr;
                if_gnt    = mem_gnt;
                off_d     = if_addr[2];
            end
        end
    end

    // Read data steering: fetch takes the addressed 32-bit half
    always_comb begin
        if_rdata = off_q ? mem_rdata[63:32] : mem_rdata[31:0];
        ls_rdata = mem_rdata;
    end

    // State, owner and fetch offset registers
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            off_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            off_q   <= off_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter.
// Checks arbitration, hold, store, reset and starvation behaviour.
module tb_mem_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [63:0] ls_addr = '0, ls_wdata = '0;
    logic [7:0]  ls_wmask = '0;
    logic        ls_gnt, ls_rvalid;
    logic [63:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    mem_arbiter #(.XLEN(64), .STARVE_LIMIT(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        ir;
        logic [63:0] ia;
        logic        lr, lw;
        logic [63:0] la, lwd;
        logic [7:0]  lm;
        logic        g, rv;
        logic [63:0] rd;
        logic        eig, eirv;
        logic [31:0] eird;
        logic        elg, elrv;
        logic [63:0] elrd;
        logic        emr, emw;
        logic [63:0] ema, emwd;
        logic [7:0]  emm;
    } vec_t;

    localparam logic [63:0] D = 64'h1122334455667788;
    localparam logic [63:0] W = 64'hDEADBEEFCAFEF00D;

    task automatic chk(input string nm, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [63:0] ia,
                         input logic lr, input logic lw,
                         input logic [63:0] la, input logic [63:0] lwd,
                         input logic [7:0] lm, input logic g,
                         input logic rv, input logic [63:0] rd);
        if_req = ir; if_addr = ia;
        ls_req = lr; ls_we = lw; ls_addr = la;
        ls_wdata = lwd; ls_wmask = lm;
        mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
    endtask

    // next cycle: drive after the rising edge, sample on the falling edge
    task automatic step;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_vec(input vec_t v, input int i);
        chk("if_gnt", i, 64'(if_gnt), 64'(v.eig));
        chk("if_rvalid", i, 64'(if_rvalid), 64'(v.eirv));
        chk("ls_gnt", i, 64'(ls_gnt), 64'(v.elg));
        chk("ls_rvalid", i, 64'(ls_rvalid), 64'(v.elrv));
        chk("mem_req", i, 64'(mem_req), 64'(v.emr));
        if (v.eirv) chk("if_rdata", i, 64'(if_rdata), 64'(v.eird));
        if (v.elrv) chk("ls_rdata", i, ls_rdata, v.elrd);
        if (v.emr) begin
            chk("mem_addr", i, mem_addr, v.ema);
            chk("mem_we", i, 64'(mem_we), 64'(v.emw));
            chk("mem_wmask", i, 64'(mem_wmask), 64'(v.emm));
        end
        if (v.emw) chk("mem_wdata", i, mem_wdata, v.emwd);
    endtask

    vec_t vt[13];

    initial begin
        // simultaneous requests: LSU wins, load mask forced to 0
        vt[0]  = '{1, 64'h80000000, 1, 0, 64'h2000, 0, 8'hFF, 1, 0, 0,
                   0, 0, 0, 1, 0, 0, 1, 0, 64'h2000, 0, 0};
        vt[1]  = '{1, 64'h80000000, 0, 0, 0, 0, 0, 0, 1, D,
                   0, 0, 0, 0, 1, D, 0, 0, 0, 0, 0};
        // waiting fetch then served, low half
        vt[2]  = '{1, 64'h80000000, 0, 0, 0, 0, 0, 1, 0, 0,
                   1, 0, 0, 0, 0, 0, 1, 0, 64'h80000000, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, D,
                   0, 1, 32'h55667788, 0, 0, 0, 0, 0, 0, 0, 0};
        // fetch held 3 cycles; LSU appears but must not steal the bus
        vt[4]  = '{1, 64'h80000004, 0, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 1, 0, 64'h80000004, 0, 0};
        vt[5]  = '{1, 64'h80000004, 1, 1, 64'h3000, 64'hAA, 8'hFF, 0, 1, D,
                   0, 0, 0, 0, 0, 0, 1, 0, 64'h80000004, 0, 0};
        vt[6]  = '{1, 64'h80000004, 1, 1, 64'h3000, 64'hAA, 8'hFF, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 1, 0, 64'h80000004, 0, 0};
        vt[7]  = '{1, 64'h80000004, 1, 1, 64'h3000, 64'hAA, 8'hFF, 1, 0, 0,
                   1, 0, 0, 0, 0, 0, 1, 0, 64'h80000004, 0, 0};
        vt[8]  = '{0, 0, 1, 1, 64'h3000, 64'hAA, 8'hFF, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[9]  = '{0, 0, 1, 1, 64'h3000, 64'hAA, 8'hFF, 0, 1, D,
                   0, 1, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0};
        // store with partial mask
        vt[10] = '{0, 0, 1, 1, 64'h1000, W, 8'h0F, 1, 0, 0,
                   0, 0, 0, 1, 0, 0, 1, 1, 64'h1000, W, 8'h0F};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                   0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        // stray response in IDLE is ignored
        vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, D,
                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    end

    vec_t z;
    int   cnt;
    int   fetch_grants;
    logic exp_ls;

    initial begin
        z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
              0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // reset state with a stray response present
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, D);
        #2;
        check_vec(z, 100);
        step();
        step();
        sys_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            step();
            drive(vt[i].ir, vt[i].ia, vt[i].lr, vt[i].lw, vt[i].la,
                  vt[i].lwd, vt[i].lm, vt[i].g, vt[i].rv, vt[i].rd);
            @(negedge sys_clk);
            check_vec(vt[i], i);
        end

        // reset while waiting for a load response
        step();
        drive(0, 0, 1, 0, 64'h4000, 0, 0, 1, 0, 0);
        @(negedge sys_clk);
        chk("rst_ls_gnt", 200, 64'(ls_gnt), 64'd1);
        step();
        sys_rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge sys_clk);
        chk("rst_mem_req", 201, 64'(mem_req), 64'd0);
        step();
        sys_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, D);
        @(negedge sys_clk);
        chk("stray_ls_rvalid", 202, 64'(ls_rvalid), 64'd0);
        chk("stray_if_rvalid", 202, 64'(if_rvalid), 64'd0);
        step();
        drive(1, 64'h40, 0, 0, 0, 0, 0, 0, 1, D);
        @(negedge sys_clk);
        chk("post_rst_idle_req", 203, 64'(mem_req), 64'd1);
        chk("post_rst_if_rvalid", 203, 64'(if_rvalid), 64'd0);
        step();
        drive(1, 64'h40, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge sys_clk);
        chk("post_rst_if_gnt", 204, 64'(if_gnt), 64'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, D);
        @(negedge sys_clk);
        chk("post_rst_if_rvalid2", 205, 64'(if_rvalid), 64'd1);
        chk("post_rst_if_rdata", 205, 64'(if_rdata), 64'h55667788);

        // continuous contention: guard pattern or strict priority
        cnt = 0;
        fetch_grants = 0;
        for (int t = 0; t < 10; t++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_ls = (cnt != 4);
`else
            exp_ls = 1'b1;
`endif
            step();
            drive(1, 64'h100, 1, 0, 64'h200, 0, 0, 1, 0, 0);
            @(negedge sys_clk);
            chk("starve_ls_gnt", 300 + t, 64'(ls_gnt), 64'(exp_ls));
            chk("starve_if_gnt", 300 + t, 64'(if_gnt), 64'(!exp_ls));
            if (if_gnt) fetch_grants++;
            cnt = exp_ls ? ((cnt < 4) ? cnt + 1 : 4) : 0;
            step();
            drive(1, 64'h100, 1, 0, 64'h200, 0, 0, 0, 1, D);
            @(negedge sys_clk);
            chk("starve_ls_rvalid", 300 + t, 64'(ls_rvalid), 64'(exp_ls));
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("fetch_grant_total", 400, 64'(fetch_grants), 64'd2);
`else
        chk("fetch_grant_total", 400, 64'(fetch_grants), 64'd0);
`endif

        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
